// File: rtl/cpu7_biu_ifetch.sv
// Instruction-fetch bus interface: accepts one IFU fetch at a time, issues a single
// outstanding memory read and returns the word, an alignment fault or a bus error.
module cpu7_biu_ifetch #(
  parameter int          GRLEN      = 32,
  parameter int          TIMEOUT    = 64,
  parameter logic [5:0]  EXC_ADEF   = 6'h08,
  parameter logic [5:0]  EXC_IBE    = 6'h3f,
  parameter logic [3:0]  UNCACHE_HI = 4'hA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic [31:0]      inst_addr,
  input  logic             inst_cancel,
  output logic             inst_ack,
  output logic             inst_addr_ok,
  output logic             inst_valid_f,
  output logic [GRLEN-1:0] inst_rdata_f,
  output logic [1:0]       inst_count,
  output logic             inst_ex,
  output logic [5:0]       inst_exccode,
  output logic             inst_uncache,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_err
);

  localparam int             TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXC, S_REQ, S_WAIT, S_DROP, S_RESP
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic [31:2]   addr_q;
  logic [31:0]   rdata_q;
  logic          ex_q;

  logic          ack_c;
  logic          timeout;
  logic          rsp_ld;
  logic [31:0]   rsp_data;
  logic          rsp_ex;
  logic          in_wd, next_wd;

  assign timeout = (timer == T_LAST);
  assign in_wd   = (state == S_WAIT) || (state == S_DROP);
  assign next_wd = (state_n == S_WAIT) || (state_n == S_DROP);

  always_comb begin
    state_n  = state;
    ack_c    = 1'b0;
    rsp_ld   = 1'b0;
    rsp_data = '0;
    rsp_ex   = 1'b0;
    case (state)
      S_IDLE: begin
        ack_c = inst_req & ~inst_cancel;
        if (ack_c) state_n = (inst_addr[1:0] != 2'b00) ? S_EXC : S_REQ;
      end
      S_EXC:  state_n = S_IDLE;
      S_REQ: begin
        if (mem_gnt)          state_n = inst_cancel ? S_DROP : S_WAIT;
        else if (inst_cancel) state_n = S_IDLE;
      end
      S_WAIT: begin
        // A cancel coinciding with the returning read consumes it, so no drain is needed.
        if (inst_cancel) begin
          state_n = mem_rvalid ? S_IDLE : S_DROP;
        end else if (mem_rvalid) begin
          state_n  = S_RESP;
          rsp_ld   = 1'b1;
          rsp_data = mem_rdata;
          rsp_ex   = mem_err;
        end else if (timeout) begin
          state_n = S_RESP;
          rsp_ld  = 1'b1;
          rsp_ex  = 1'b1;
        end
      end
      S_DROP: if (mem_rvalid || timeout) state_n = S_IDLE;
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      ex_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (in_wd && next_wd) timer <= timeout ? timer : timer + 1'b1;
      else                  timer <= '0;
      if (ack_c) addr_q <= inst_addr[31:2];
      if (rsp_ld) begin
        rdata_q <= rsp_data;
        ex_q    <= rsp_ex;
      end
    end
  end

  always_comb begin
    inst_valid_f = ((state == S_EXC) || (state == S_RESP)) && !inst_cancel;
    inst_ex      = inst_valid_f && ((state == S_EXC) || ex_q);
    inst_exccode = '0;
    if (inst_ex) inst_exccode = (state == S_EXC) ? EXC_ADEF : EXC_IBE;
    inst_rdata_f = (inst_valid_f && (state == S_RESP)) ? GRLEN'(rdata_q) : '0;
    inst_uncache = inst_valid_f && (addr_q[31:28] == UNCACHE_HI);
  end

  assign inst_ack     = ack_c & ~reset;
  assign inst_addr_ok = inst_ack;
  assign inst_count   = 2'd1;
  assign mem_req      = (state == S_REQ);
  assign mem_addr     = mem_req ? {addr_q, 2'b00} : '0;

endmodule

// File: tb/tb_cpu7_biu_ifetch.sv
// Bench for cpu7_biu_ifetch: each fetch is planned as a cycle timeline derived from the
// handshake rules, then driven cycle by cycle and compared against that timeline.
module tb_cpu7_biu_ifetch;

  localparam int TIMEOUT = 64;
  localparam int NEVER   = 1 << 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr;
  logic        inst_ack, inst_addr_ok, inst_valid_f, inst_ex, inst_uncache;
  logic [31:0] inst_rdata_f;
  logic [1:0]  inst_count;
  logic [5:0]  inst_exccode;
  logic        mem_req, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  cpu7_biu_ifetch #(
    .GRLEN(32), .TIMEOUT(TIMEOUT), .EXC_ADEF(6'h08), .EXC_IBE(6'h3f), .UNCACHE_HI(4'hA)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_ack(inst_ack), .inst_addr_ok(inst_addr_ok), .inst_valid_f(inst_valid_f),
    .inst_rdata_f(inst_rdata_f), .inst_count(inst_count), .inst_ex(inst_ex),
    .inst_exccode(inst_exccode), .inst_uncache(inst_uncache),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Cycle (relative to ack) at which the WAIT phase ends, by rvalid or by watchdog.
  function automatic int wait_end(input int g, input int r);
    int G, R, TO;
    G  = 1 + g;
    R  = (r < 0) ? NEVER : G + 1 + r;
    TO = G + TIMEOUT;
    return (R < TO) ? R : TO;
  endfunction

  // One fetch: g = cycles in REQ before grant, r = WAIT cycles before rvalid (-1 = never),
  // k = cycle after ack carrying a one-cycle inst_cancel (-1 = none).
  task automatic run_trans(input logic [31:0] addr, input int g, input int r,
                           input logic err, input int k, input logic [31:0] data);
    int G, R, TO, E, D, SV, N, req_end;
    bit mis, tmo, gnt_on, rv_on;
    logic [31:0] x_rdata;
    logic        x_ex, x_unc;
    logic [5:0]  x_code;
    mis = (addr[1:0] != 2'b00);
    G   = 1 + g;
    R   = (r < 0) ? NEVER : G + 1 + r;
    TO  = G + TIMEOUT;
    E   = wait_end(g, r);
    tmo = (R > TO);
    gnt_on = 0; rv_on = 0; req_end = 0;
    if (mis) begin
      SV = (k == 1) ? -1 : 1;
      N  = 2;
    end else begin
      gnt_on = 1; rv_on = !tmo; req_end = G;
      SV = E + 1; N = E + 2;
      if (k >= 1 && k < G) begin
        SV = -1; N = k + 1; gnt_on = 0; rv_on = 0; req_end = k;
      end else if (k >= G && k <= E) begin
        SV = -1;
        if (k == R) N = k + 1;
        else begin
          D = (TO > k) ? TO : k + 1;
          if (R > k && R < D) D = R;
          N = D + 1;
        end
      end else if (k == E + 1) begin
        SV = -1;
      end
    end
    x_ex    = mis || tmo || err;
    x_rdata = (mis || tmo) ? 32'h0 : data;
    x_code  = mis ? 6'h08 : (x_ex ? 6'h3f : 6'h00);
    x_unc   = (addr[31:28] == 4'hA);

    for (int t = 0; t < N; t++) begin
      @(negedge clk);
      inst_req    = 1'b1;
      inst_addr   = addr;
      inst_cancel = (t == k);
      mem_gnt     = gnt_on && (t == G);
      mem_rvalid  = rv_on && (t == R);
      mem_err     = rv_on && (t == R) && err;
      mem_rdata   = (t == R) ? data : $urandom;
      #1;
      check("ack", {31'b0, inst_ack}, {31'b0, t == 0});
      check("addr_ok", {31'b0, inst_addr_ok}, {31'b0, t == 0});
      check("mem_req", {31'b0, mem_req}, {31'b0, !mis && t >= 1 && t <= req_end});
      if (!mis && t >= 1 && t <= req_end) check("mem_addr", mem_addr, {addr[31:2], 2'b00});
      check("valid", {31'b0, inst_valid_f}, {31'b0, t == SV});
      if (t == SV) begin
        check("rdata", inst_rdata_f, x_rdata);
        check("ex", {31'b0, inst_ex}, {31'b0, x_ex});
        check("exccode", {26'b0, inst_exccode}, {26'b0, x_code});
        check("uncache", {31'b0, inst_uncache}, {31'b0, x_unc});
        check("count", {30'b0, inst_count}, 32'd1);
      end else begin
        check("idle_data", {inst_rdata_f[31:7], inst_ex, inst_exccode} | {25'b0, inst_rdata_f[6:0]}, 32'h0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] a;
    int g, r, k, p, kmax;
    reset = 1'b1; inst_req = 1'b0; inst_cancel = 1'b0; inst_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    @(negedge clk);
    inst_req = 1'b1;
    #1;
    check("rst_outs", {26'b0, inst_ack, inst_addr_ok, inst_valid_f, inst_ex, inst_uncache, mem_req}, 32'h0);
    check("rst_count", {30'b0, inst_count}, 32'd1);
    @(negedge clk);
    reset = 1'b0; inst_req = 1'b0;

    run_trans(32'h1c000000, 0, 0, 1'b0, -1, 32'h02800421);
    run_trans(32'h1c000002, 0, 0, 1'b0, -1, 32'h0);
    run_trans(32'h1c000010, 0, 3, 1'b0, 2, 32'hdeadbeef);
    run_trans(32'h1c000100, 1, 2, 1'b0, -1, 32'h12345678);
    run_trans(32'h1c000200, 0, 1, 1'b1, -1, 32'h0badf00d);
    run_trans(32'h1c000300, 0, -1, 1'b0, -1, 32'h0);
    run_trans(32'hA0000000, 2, 0, 1'b0, -1, 32'h0a0b0c0d);
    run_trans(32'h1c000400, 0, 2, 1'b0, 4, 32'h11112222);
    run_trans(32'h1c000500, 3, 0, 1'b0, 2, 32'h33334444);
    run_trans(32'h1c000600, 0, 0, 1'b0, 3, 32'h55556666);
    run_trans(32'h1c000601, 0, 0, 1'b0, 1, 32'h0);
    run_trans(32'h1c000700, 0, -1, 1'b0, 1, 32'h0);
    run_trans(32'h1c000800, 0, 63, 1'b0, -1, 32'h77778888);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) a[31:28] = 4'hA;
      g = $urandom_range(0, 3);
      p = $urandom_range(0, 9);
      r = (p == 0) ? -1 : (p == 1) ? 63 : $urandom_range(0, 6);
      kmax = (a[1:0] != 2'b00) ? 1 : wait_end(g, r) + 1;
      k = ($urandom_range(0, 1) == 0) ? -1 : 1 + $urandom_range(0, kmax - 1);
      run_trans(a, g, r, ($urandom_range(0, 3) == 0), k, $urandom);
    end

    // Reset during WAIT, then a late read return that must be ignored.
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c000000; inst_cancel = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    #1 check("r_ack", {31'b0, inst_ack}, 32'd1);
    @(negedge clk);
    inst_req = 1'b0; mem_gnt = 1'b1;
    #1 check("r_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    mem_gnt = 1'b0;
    @(negedge clk);
    reset = 1'b1; inst_req = 1'b1;
    #1;
    check("r_outs", {26'b0, inst_ack, inst_addr_ok, inst_valid_f, inst_ex, inst_uncache, mem_req}, 32'h0);
    check("r_data", inst_rdata_f | mem_addr | {26'b0, inst_exccode}, 32'h0);
    check("r_count", {30'b0, inst_count}, 32'd1);
    @(negedge clk);
    reset = 1'b0; inst_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hcafef00d;
    #1 check("r_late0", {31'b0, inst_valid_f | mem_req}, 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1 check("r_late1", {31'b0, inst_valid_f | mem_req}, 32'd0);
    run_trans(32'h1c000000, 0, 0, 1'b0, -1, 32'h02800421);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu7_biu_ifetch.md
Name: cpu7_biu_ifetch

Overview:
- Responder end of the IFU instruction-fetch handshake (inst_req/inst_addr/inst_cancel in; inst_ack/inst_addr_ok/inst_valid_f/inst_rdata_f/inst_ex out).
- Sits between cpu7 IFU fetch datapath and a single-outstanding memory read port.
- Accepts one fetch at a time, checks alignment, issues the memory read, and returns the instruction word or an exception.
- Handles mid-flight cancellation from branch, exception and ertn redirects, plus a response watchdog.

Parameters:
GRLEN, 32, data width of inst_rdata_f
TIMEOUT, 64, max cycles in WAIT before a bus-error response (>=2)
EXC_ADEF, 6'h08, exccode for misaligned fetch address
EXC_IBE, 6'h3f, exccode for memory error or timeout
UNCACHE_HI, 4'hA, inst_addr[31:28] value marking an uncached region

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
inst_req  in  1  IFU fetch request
inst_addr  in  32  fetch address, sampled on inst_ack
inst_cancel  in  1  IFU kills the outstanding or presented fetch
inst_ack  out  1  request accepted this cycle
inst_addr_ok  out  1  equal to inst_ack
inst_valid_f  out  1  one-cycle response strobe
inst_rdata_f  out  GRLEN  instruction word, zero-extended
inst_count  out  2  instructions returned; constant 2'd1
inst_ex  out  1  response carries an exception, valid with inst_valid_f
inst_exccode  out  6  exception code, valid with inst_ex
inst_uncache  out  1  fetched address is in the uncached region, valid with inst_valid_f
mem_req  out  1  memory read request
mem_addr  out  32  word-aligned read address
mem_gnt  in  1  memory accepted mem_req
mem_rvalid  in  1  read data returned
mem_rdata  in  32  read data
mem_err  in  1  read error, qualifies mem_rvalid

Behaviour:
- Reset: state=IDLE, timer=0, latched addr=0. All outputs 0 except inst_count=2'd1. Reset mid-operation abandons any transaction; a later mem_rvalid is ignored in IDLE.
- FSM states: IDLE, EXC, REQ, WAIT, DROP, RESP.
- IDLE:
  - inst_ack = inst_req & ~inst_cancel, combinational, asserted only in IDLE.
  - On ack, latch inst_addr. If addr[1:0]!=0 go to EXC, else go to REQ.
  - mem_rvalid is ignored in IDLE.
- EXC: no memory access. Next cycle inst_valid_f=1, inst_ex=1, inst_exccode=EXC_ADEF, rdata=0, then IDLE. inst_cancel in EXC suppresses the strobe and returns to IDLE.
- REQ:
  - mem_req=1, mem_addr = {addr[31:2],2'b00}.
  - mem_gnt: go to WAIT, timer=0.
  - inst_cancel without mem_gnt: withdraw mem_req and go to IDLE.
  - inst_cancel with mem_gnt: go to DROP.
- WAIT:
  - timer increments every cycle.
  - mem_rvalid & ~inst_cancel: register rdata/err and go to RESP.
  - inst_cancel, including the same cycle as mem_rvalid: go to DROP, or to IDLE if mem_rvalid is also high. Data is discarded.
  - timer==TIMEOUT-1 without rvalid: go to RESP with a bus error.
- DROP: wait for mem_rvalid or timer==TIMEOUT-1, then IDLE. No inst_valid_f. inst_ack stays 0, so a new IFU request waits.
- RESP: one cycle with inst_valid_f=1.
  - inst_rdata_f = registered data.
  - inst_ex = err|timeout; inst_exccode = EXC_IBE when inst_ex, else 0.
  - inst_uncache = (addr[31:28]==UNCACHE_HI).
  - inst_cancel in RESP suppresses inst_valid_f (IFU kill wins).
  - Next state IDLE. A new inst_ack is possible in the following cycle, not in the same cycle.
- Latencies:
  - Minimum ack to inst_valid_f = 3 cycles (ack in IDLE, mem_gnt in REQ, mem_rvalid in WAIT, strobe in RESP).
  - Misaligned fetch: ack to inst_valid_f = 1 cycle.
- Invariants:
  - At most one outstanding memory read.
  - inst_valid_f never asserts without a preceding un-cancelled ack.
  - inst_rdata_f, inst_ex and inst_exccode are 0 whenever inst_valid_f=0.
- Timer width is clog2(TIMEOUT); it saturates and is cleared on leaving WAIT/DROP.

Test Plan:
- Aligned fetch: inst_req, addr=0x1c000000; gnt next cycle; rvalid 1 cycle later with rdata=0x02800421 -> ack at T0, mem_addr=0x1c000000, inst_valid_f at T3 with 0x02800421, inst_ex=0, inst_uncache=0.
- Misaligned: addr=0x1c000002 -> ack, no mem_req ever, inst_valid_f at T1 with inst_ex=1, exccode=6'h08.
- Cancel in WAIT: ack addr=0x1c000010, gnt, then inst_cancel; rvalid 3 cycles later -> no inst_valid_f; inst_req (addr=0x1c000100) held high gets ack only the cycle after rvalid; second fetch completes normally.
- Error and timeout:
  - mem_err with rvalid -> inst_valid_f, inst_ex=1, exccode=6'h3f.
  - No rvalid for 64 cycles in WAIT -> same bus-error response at cycle 64.
  - addr=0xA0000000 -> inst_uncache=1.
- Simultaneous events:
  - inst_cancel same cycle as mem_rvalid -> no strobe, IDLE next cycle.
  - reset asserted in WAIT -> all outputs 0 immediately; late rvalid ignored; next fetch after reset release behaves as the aligned-fetch scenario.
